// File: rtl/vic_bus_arbiter_if.sv
// rtl/vic_bus_arbiter_if.sv - strobe/register inputs and bus-ownership outputs of the VIC-II bus arbiter
//
// Signals:
//   i_phi1Strobe  1   pulse at the start of each phi1 (VIC) half
//   i_phi2Strobe  1   pulse at the start of each phi2 (CPU) half
//   i_den         1   display enable ($D011 bit 4)
//   i_yscroll     3   vertical fine scroll ($D011 bits 2:0)
//   o_ba          1   bus available to the CPU
//   o_aec         1   CPU drives the address bus
//   o_badline     1   current raster line is a badline
//   o_cycle       6   cycle within the line, 1..CYCLES_PER_LINE
//   o_raster      9   raster line
//   o_stealCount  16  stolen phi2 halves in the last completed frame
// Modports: master drives the inputs and observes the outputs, slave is the arbiter.

interface vic_bus_arbiter_if;
    logic        i_phi1Strobe;
    logic        i_phi2Strobe;
    logic        i_den;
    logic [2:0]  i_yscroll;
    logic        o_ba;
    logic        o_aec;
    logic        o_badline;
    logic [5:0]  o_cycle;
    logic [8:0]  o_raster;
    logic [15:0] o_stealCount;

    modport master (
        output i_phi1Strobe, i_phi2Strobe, i_den, i_yscroll,
        input  o_ba, o_aec, o_badline, o_cycle, o_raster, o_stealCount
    );

    modport slave (
        input  i_phi1Strobe, i_phi2Strobe, i_den, i_yscroll,
        output o_ba, o_aec, o_badline, o_cycle, o_raster, o_stealCount
    );
endinterface

// File: rtl/vic_bus_arbiter.sv
// rtl/vic_bus_arbiter.sv - CPU/VIC-II shared bus arbitration with PAL raster tracking and badline detection
//
// Ports:
//   clkSys  in  system clock, rising edge
//   reset   in  asynchronous active-low reset
//   bus     slave modport of vic_bus_arbiter_if (phi strobes, DEN/YSCROLL in; BA, AEC, badline,
//           cycle, raster, steal count out)
// Optional feature: define VIC_STEAL_CNT_EN to build the per-frame stolen-phi2 counter;
// without it o_stealCount is tied to zero.

module vic_bus_arbiter #(
    parameter int CYCLES_PER_LINE = 63,
    parameter int LINES_PER_FRAME = 312,
    parameter int BA_LEAD         = 3,
    parameter int FIRST_C_CYCLE   = 15,
    parameter int LAST_C_CYCLE    = 54,
    parameter int BADLINE_FIRST   = 'h030,
    parameter int BADLINE_LAST    = 'h0F7
) (
    input  logic               clkSys,
    input  logic               reset,
    vic_bus_arbiter_if.slave   bus
);

    localparam logic [5:0] CYC_LAST = 6'(CYCLES_PER_LINE);
    localparam logic [8:0] RAS_LAST = 9'(LINES_PER_FRAME - 1);
    localparam logic [5:0] BA_START = 6'(FIRST_C_CYCLE - BA_LEAD);
    localparam logic [5:0] C_FIRST  = 6'(FIRST_C_CYCLE);
    localparam logic [5:0] C_LAST   = 6'(LAST_C_CYCLE);
    localparam logic [8:0] BL_FIRST = 9'(BADLINE_FIRST);
    localparam logic [8:0] BL_LAST  = 9'(BADLINE_LAST);
    localparam logic [1:0] LEAD     = 2'(BA_LEAD);

    logic [5:0] cycle;
    logic [8:0] raster;
    logic       den_seen;
    logic       badline;
    logic       ba;
    logic       aec;
    logic [1:0] ba_low_cnt;

    logic       cycle_wrap;
    logic       raster_wrap;
    logic [5:0] cycle_n;
    logic [8:0] raster_n;
    logic       den_ok;
    logic       badline_n;
    logic       ba_n;
    logic       steal;

    // Next position and the badline/BA decision are evaluated against the position the
    // phi1 strobe moves to, so o_ba always agrees with the o_cycle/o_badline shown beside it.
    always_comb begin
        cycle_wrap  = (cycle == CYC_LAST);
        raster_wrap = cycle_wrap && (raster == RAS_LAST);
        cycle_n     = cycle_wrap ? 6'd1 : cycle + 6'd1;
        raster_n    = raster;
        if (cycle_wrap) begin
            raster_n = raster_wrap ? 9'd0 : raster + 9'd1;
        end
        den_ok    = den_seen || ((raster_n == BL_FIRST) && bus.i_den);
        badline_n = (raster_n >= BL_FIRST) && (raster_n <= BL_LAST)
                    && (raster_n[2:0] == bus.i_yscroll) && den_ok;
        ba_n      = !(badline_n && (cycle_n >= BA_START) && (cycle_n <= C_LAST));
        // phi2 is stolen only once BA has been low for BA_LEAD full phi1 strobes, which
        // delays the first c-access of a badline that starts late in the line.
        steal     = !ba && (ba_low_cnt >= LEAD) && (cycle >= C_FIRST) && (cycle <= C_LAST);
    end

    always_ff @(posedge clkSys or negedge reset) begin
        if (!reset) begin
            cycle      <= 6'd1;
            raster     <= 9'd0;
            den_seen   <= 1'b0;
            badline    <= 1'b0;
            ba         <= 1'b1;
            aec        <= 1'b1;
            ba_low_cnt <= 2'd0;
        end else if (bus.i_phi1Strobe) begin
            cycle   <= cycle_n;
            raster  <= raster_n;
            badline <= badline_n;
            ba      <= ba_n;
            aec     <= 1'b0;
            if (raster_wrap) begin
                den_seen <= 1'b0;
            end else if ((raster == BL_FIRST) && bus.i_den) begin
                den_seen <= 1'b1;
            end
            // Counts strobes that found BA already low, saturating at 3.
            if (ba) begin
                ba_low_cnt <= 2'd0;
            end else if (ba_low_cnt != 2'd3) begin
                ba_low_cnt <= ba_low_cnt + 2'd1;
            end
        end else if (bus.i_phi2Strobe) begin
            aec <= !steal;
        end
    end

    assign bus.o_cycle   = cycle;
    assign bus.o_raster  = raster;
    assign bus.o_badline = badline;
    assign bus.o_ba      = ba;
    assign bus.o_aec     = aec;

`ifdef VIC_STEAL_CNT_EN
    logic [15:0] steal_acc;
    logic [15:0] steal_count;

    always_ff @(posedge clkSys or negedge reset) begin
        if (!reset) begin
            steal_acc   <= 16'h0000;
            steal_count <= 16'h0000;
        end else if (bus.i_phi1Strobe) begin
            if (raster_wrap) begin
                steal_count <= steal_acc;
                steal_acc   <= 16'h0000;
            end
        end else if (bus.i_phi2Strobe && steal && (steal_acc != 16'hFFFF)) begin
            steal_acc <= steal_acc + 16'h0001;
        end
    end

    assign bus.o_stealCount = steal_count;
`else
    assign bus.o_stealCount = 16'h0000;
`endif

endmodule

// File: tb/tb_vic_bus_arbiter.sv
// tb/tb_vic_bus_arbiter.sv - scoreboard bench for vic_bus_arbiter with a behavioural raster/steal model

`timescale 1ns/1ps

module tb_vic_bus_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vic_bus_arbiter_if bus_if();

    vic_bus_arbiter dut (
        .clkSys (clk),
        .reset  (rst_n),
        .bus    (bus_if)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int cycle;
        int raster;
        bit badline;
        bit ba;
        bit aec;
        int steal;
    } exp_t;

    exp_t exp_q[$];

    int m_cycle, m_raster, m_low_run, m_acc, m_steal_out;
    bit m_den_seen, m_badline, m_ba, m_aec;

    bit       tb_den;
    bit [2:0] tb_ys;
    bit       gaps_en;

    task automatic model_reset();
        m_cycle = 1; m_raster = 0; m_low_run = 0; m_acc = 0; m_steal_out = 0;
        m_den_seen = 0; m_badline = 0; m_ba = 1; m_aec = 1;
        exp_q.delete();
    endtask

    task automatic model_step(input bit p1, input bit p2, input bit den, input bit [2:0] ys);
        int  old_r;
        bit  old_ba;
        bit  old_seen;
        if (p1) begin
            old_r = m_raster; old_ba = m_ba; old_seen = m_den_seen;
            if (m_cycle == 63) begin
                m_cycle  = 1;
                m_raster = (m_raster + 1) % 312;
            end else begin
                m_cycle = m_cycle + 1;
            end
            if (m_cycle == 1 && m_raster == 0) begin
                m_steal_out = m_acc;
                m_acc = 0;
                m_den_seen = 0;
            end else if (old_r == 48 && den) begin
                m_den_seen = 1;
            end
            m_badline = (m_raster >= 48) && (m_raster <= 247) && ((m_raster % 8) == ys)
                        && (old_seen || (m_raster == 48 && den));
            m_ba = !(m_badline && m_cycle >= 12 && m_cycle <= 54);
            m_low_run = old_ba ? 0 : m_low_run + 1;
            m_aec = 0;
        end else if (p2) begin
            m_aec = !(!m_ba && m_low_run >= 3 && m_cycle >= 15 && m_cycle <= 54);
            if (!m_aec && m_acc < 65535) m_acc = m_acc + 1;
        end
    endtask

    function automatic int exp_steal();
`ifdef VIC_STEAL_CNT_EN
        return m_steal_out;
`else
        return 0;
`endif
    endfunction

    // ---------------- driver ----------------
    task automatic issue(input bit p1, input bit p2);
        exp_t e;
        @(negedge clk);
        bus_if.i_phi1Strobe = p1;
        bus_if.i_phi2Strobe = p2;
        bus_if.i_den        = tb_den;
        bus_if.i_yscroll    = tb_ys;
        model_step(p1, p2, tb_den, tb_ys);
        e.cycle = m_cycle; e.raster = m_raster; e.badline = m_badline;
        e.ba = m_ba; e.aec = m_aec; e.steal = exp_steal();
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus_if.i_phi1Strobe = 1'b0;
        bus_if.i_phi2Strobe = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
    endtask

    task automatic step_cycle();
        if (gaps_en && $urandom_range(0, 15) == 0) idle();
        issue(1'b1, 1'b0);
        issue(1'b0, 1'b1);
    endtask

    task automatic run_to(input int r, input int c);
        int n = 0;
        while (!(m_raster == r && m_cycle == c) && n < 25000) begin
            step_cycle();
            n++;
        end
        check("run_to_reached", (m_raster == r && m_cycle == c), 1);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int obs_bad[512], obs_steal[512], obs_fall[512], obs_rise[512], obs_first[512], obs_last[512];

    task automatic clear_obs();
        for (int i = 0; i < 512; i++) begin
            obs_bad[i] = 0; obs_steal[i] = 0; obs_fall[i] = 0;
            obs_rise[i] = 0; obs_first[i] = 0; obs_last[i] = 0;
        end
    endtask

    initial begin
        bit   s1, s2;
        exp_t e;
        int   r, c;
        forever begin
            @(posedge clk);
            s1 = bus_if.i_phi1Strobe;
            s2 = bus_if.i_phi2Strobe;
            if (rst_n && (s1 || s2)) begin
                @(negedge clk);
                if (exp_q.size() == 0) begin
                    check("scoreboard_nonempty", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    check("cycle",      bus_if.o_cycle,      e.cycle);
                    check("raster",     bus_if.o_raster,     e.raster);
                    check("badline",    bus_if.o_badline,    e.badline);
                    check("ba",         bus_if.o_ba,         e.ba);
                    check("aec",        bus_if.o_aec,        e.aec);
                    check("steal_count", bus_if.o_stealCount, e.steal);
                end
                r = int'(bus_if.o_raster);
                c = int'(bus_if.o_cycle);
                if (bus_if.o_badline) obs_bad[r] = 1;
                if (!bus_if.o_ba && obs_fall[r] == 0) obs_fall[r] = c;
                if (bus_if.o_ba && obs_fall[r] != 0 && obs_rise[r] == 0) obs_rise[r] = c;
                if (s2 && !s1 && !bus_if.o_aec) begin
                    obs_steal[r]++;
                    if (obs_first[r] == 0) obs_first[r] = c;
                    obs_last[r] = c;
                end
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    // ---------------- stimulus ----------------
    task automatic pulse_reset_and_check();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_cycle",   bus_if.o_cycle,      1);
        check("rst_raster",  bus_if.o_raster,     0);
        check("rst_ba",      bus_if.o_ba,         1);
        check("rst_aec",     bus_if.o_aec,        1);
        check("rst_badline", bus_if.o_badline,    0);
        check("rst_steal",   bus_if.o_stealCount, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int nbad;
        int k;
        bus_if.i_phi1Strobe = 1'b0;
        bus_if.i_phi2Strobe = 1'b0;
        bus_if.i_den        = 1'b0;
        bus_if.i_yscroll    = 3'd0;
        tb_den = 0; tb_ys = 0; gaps_en = 0;
        model_reset();
        clear_obs();
        repeat (3) @(posedge clk);
        pulse_reset_and_check();

        // one line of phi1 strobes only
        repeat (63) issue(1'b1, 1'b0);
        @(negedge clk);
        check("line_wrap_cycle",  bus_if.o_cycle,  1);
        check("line_wrap_raster", bus_if.o_raster, 1);

        // full frame, den=1 yscroll=0
        tb_den = 1; tb_ys = 0; gaps_en = 1;
        clear_obs();
        run_to(0, 1);
        @(negedge clk);
        check("l30_ba_fall",    obs_fall[48],  12);
        check("l30_ba_rise",    obs_rise[48],  55);
        check("l30_steals",     obs_steal[48], 40);
        check("l30_first_steal", obs_first[48], 15);
        check("l30_last_steal", obs_last[48],  54);
        nbad = 0;
        for (int i = 0; i < 312; i++) nbad += obs_bad[i];
        check("frame_badlines", nbad, 25);
`ifdef VIC_STEAL_CNT_EN
        check("frame_steal_count", bus_if.o_stealCount, 1000);
`else
        check("frame_steal_count", bus_if.o_stealCount, 0);
`endif

        // yscroll=3: $30 not a badline, $33 is
        pulse_reset_and_check();
        tb_den = 1; tb_ys = 3;
        clear_obs();
        run_to(52, 1);
        check("ys3_l30_bad", obs_bad[48], 0);
        check("ys3_l33_bad", obs_bad[51], 1);

        // randomized segment: yscroll/den changes, coincident strobes, extra phi2, gaps
        for (int i = 0; i < 3000; i++) begin
            k = $urandom_range(0, 199);
            if (k < 2) tb_ys = 3'($urandom_range(0, 7));
            else if (k == 2) tb_den = ~tb_den;
            k = $urandom_range(0, 15);
            if (k == 0) issue(1'b1, 1'b1);
            else if (k == 1) idle();
            else if (k == 2) issue(1'b0, 1'b1);
            else step_cycle();
        end

        // den=0 throughout line $30: no badlines afterwards
        pulse_reset_and_check();
        tb_den = 0; tb_ys = 0;
        clear_obs();
        run_to(65, 1);
        nbad = 0;
        for (int i = 0; i < 66; i++) nbad += obs_bad[i];
        check("den0_badlines", nbad, 0);

        // yscroll matched mid-line at cycle 20 of $31
        pulse_reset_and_check();
        tb_den = 1; tb_ys = 0;
        clear_obs();
        run_to(49, 20);
        tb_ys = 1;
        run_to(50, 1);
        check("late_ba_fall",     obs_fall[49],  21);
        check("late_first_steal", obs_first[49], 24);
        check("late_last_steal",  obs_last[49],  54);
        check("late_steals",      obs_steal[49], 31);
        check("late_ba_rise",     obs_rise[49],  55);

        // reset in the middle of badline $32
        tb_ys = 2;
        run_to(50, 30);
        @(negedge clk);
        check("pre_rst_ba",  bus_if.o_ba,  0);
        check("pre_rst_aec", bus_if.o_aec, 0);
        pulse_reset_and_check();
        issue(1'b1, 1'b0);
        @(negedge clk);
        check("post_rst_cycle", bus_if.o_cycle, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
